// File: rtl/usb_rx_packet_fsm.sv
// rtl/usb_rx_packet_fsm.sv - USB packet receive FSM: SYNC/PID/token/data framing, CRC holdback, error report
// Optional PID complement check: define USB_RX_PID_CHECK_EN.
module usb_rx_packet_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_ready_RX,
    input  logic [7:0]  byte_RX,
    input  logic        eop_RX,
    output logic [3:0]  RX_Packet,
    output logic        RX_Data_Ready,
    output logic        RX_Transfer_Active,
    output logic        RX_Error,
    output logic        store_RX_data,
    output logic [7:0]  RX_data,
    output logic [15:0] token_RX,
    output logic [2:0]  c_state_RX
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PID   = 3'd1;
    localparam logic [2:0] S_TOKEN = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_HSK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    localparam logic [7:0] SYNC_BYTE = 8'h01;
    localparam logic [6:0] CNT_LAST  = 7'd66;

    logic [2:0]  state_q, state_d;
    logic [3:0]  pid_q;
    logic [3:0]  packet_q;
    logic [6:0]  cnt_q;
    logic [7:0]  h0_q, h1_q;
    logic [7:0]  data_q;
    logic        store_q;
    logic        err_q;
    logic [15:0] token_q;

    logic [3:0]  nib;
    logic        pid_known;
    logic        pid_valid;
    logic        byte_only;

    assign nib       = byte_RX[3:0];
    assign byte_only = byte_ready_RX && !eop_RX;
    assign pid_known = (nib == PID_OUT) || (nib == PID_IN) ||
                       (nib == PID_DATA0) || (nib == PID_ACK);

`ifdef USB_RX_PID_CHECK_EN
    assign pid_valid = pid_known && (byte_RX[7:4] == ~nib);
`else
    assign pid_valid = pid_known;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A strobe pair (byte + eop together) mid-packet is always a framing error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (byte_ready_RX) begin
                    state_d = (byte_RX == SYNC_BYTE) ? S_PID : S_ERROR;
                end
            end
            S_PID: begin
                if (eop_RX) begin
                    state_d = S_ERROR;
                end else if (byte_ready_RX) begin
                    if (!pid_valid) begin
                        state_d = S_ERROR;
                    end else if (nib == PID_OUT || nib == PID_IN) begin
                        state_d = S_TOKEN;
                    end else if (nib == PID_DATA0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_HSK;
                    end
                end
            end
            S_TOKEN: begin
                if (eop_RX) begin
                    state_d = (byte_ready_RX || cnt_q != 7'd2) ? S_ERROR : S_DONE;
                end else if (byte_ready_RX && cnt_q == 7'd2) begin
                    state_d = S_ERROR;
                end
            end
            S_DATA: begin
                if (eop_RX) begin
                    state_d = (byte_ready_RX || cnt_q < 7'd2) ? S_ERROR : S_DONE;
                end else if (byte_ready_RX && cnt_q == CNT_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_HSK: begin
                if (eop_RX) begin
                    state_d = byte_ready_RX ? S_ERROR : S_DONE;
                end else if (byte_ready_RX) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: begin
                if (eop_RX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        RX_Transfer_Active = (state_q == S_PID) || (state_q == S_TOKEN) ||
                             (state_q == S_DATA) || (state_q == S_HSK);
        RX_Data_Ready      = (state_q == S_DONE);
        c_state_RX         = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pid_q    <= 4'd0;
            packet_q <= 4'd0;
            cnt_q    <= 7'd0;
            h0_q     <= 8'd0;
            h1_q     <= 8'd0;
            data_q   <= 8'd0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            token_q  <= 16'd0;
        end else begin
            store_q <= 1'b0;

            if (state_d == S_ERROR) begin
                err_q <= 1'b1;
            end else if (state_q == S_IDLE && byte_ready_RX && byte_RX == SYNC_BYTE) begin
                err_q <= 1'b0;
            end

            if (state_d == S_DONE) begin
                packet_q <= pid_q;
            end

            case (state_q)
                S_PID: begin
                    if (byte_only) begin
                        pid_q <= nib;
                        cnt_q <= 7'd0;
                        h0_q  <= 8'd0;
                        h1_q  <= 8'd0;
                    end
                end
                S_TOKEN: begin
                    if (byte_only && cnt_q < 7'd2) begin
                        if (cnt_q == 7'd0) begin
                            token_q[15:8] <= byte_RX;
                        end else begin
                            token_q[7:0] <= byte_RX;
                        end
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_DATA: begin
                    // The last two bytes seen are the CRC; only older bytes are released.
                    if (byte_only && cnt_q != CNT_LAST) begin
                        if (cnt_q >= 7'd2) begin
                            store_q <= 1'b1;
                            data_q  <= h1_q;
                        end
                        h1_q  <= h0_q;
                        h0_q  <= byte_RX;
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RX_Packet     = packet_q;
    assign RX_Error      = err_q;
    assign store_RX_data = store_q;
    assign RX_data       = data_q;
    assign token_RX      = token_q;

endmodule

// File: tb/tb_usb_rx_packet_fsm.sv
// tb/tb_usb_rx_packet_fsm.sv - directed self-checking bench for usb_rx_packet_fsm
module tb_usb_rx_packet_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_ready_RX;
    logic [7:0]  byte_RX;
    logic        eop_RX;
    logic [3:0]  RX_Packet;
    logic        RX_Data_Ready;
    logic        RX_Transfer_Active;
    logic        RX_Error;
    logic        store_RX_data;
    logic [7:0]  RX_data;
    logic [15:0] token_RX;
    logic [2:0]  c_state_RX;

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    logic [7:0] stores[$];

    usb_rx_packet_fsm dut (
        .clk                (clk),
        .rst                (rst),
        .byte_ready_RX      (byte_ready_RX),
        .byte_RX            (byte_RX),
        .eop_RX             (eop_RX),
        .RX_Packet          (RX_Packet),
        .RX_Data_Ready      (RX_Data_Ready),
        .RX_Transfer_Active (RX_Transfer_Active),
        .RX_Error           (RX_Error),
        .store_RX_data      (store_RX_data),
        .RX_data            (RX_data),
        .token_RX           (token_RX),
        .c_state_RX         (c_state_RX)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (RX_Data_Ready) ready_cnt++;
        if (store_RX_data) stores.push_back(RX_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        byte_ready_RX = 1'b1;
        byte_RX = b;
        @(negedge clk);
        byte_ready_RX = 1'b0;
    endtask

    task automatic send_eop();
        eop_RX = 1'b1;
        @(negedge clk);
        eop_RX = 1'b0;
    endtask

    task automatic send_both(input logic [7:0] b);
        byte_ready_RX = 1'b1;
        eop_RX = 1'b1;
        byte_RX = b;
        @(negedge clk);
        byte_ready_RX = 1'b0;
        eop_RX = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        byte_ready_RX = 1'b0;
        byte_RX = 8'h00;
        eop_RX = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", c_state_RX, 0);
        chk("rst_packet", RX_Packet, 0);
        chk("rst_ready", RX_Data_Ready, 0);
        chk("rst_active", RX_Transfer_Active, 0);
        chk("rst_err", RX_Error, 0);
        chk("rst_store", store_RX_data, 0);
        chk("rst_data", RX_data, 0);
        chk("rst_token", token_RX, 0);
        rst = 1'b0;
        tick();

        // ACK handshake
        send_eop();
        chk("idle_eop_ignored", c_state_RX, 0);
        send_byte(8'h01);
        chk("ack_pid_state", c_state_RX, 1);
        chk("ack_active", RX_Transfer_Active, 1);
        send_byte(8'hD2);
        chk("ack_hsk_state", c_state_RX, 4);
        send_eop();
        chk("ack_done_state", c_state_RX, 5);
        chk("ack_ready", RX_Data_Ready, 1);
        chk("ack_packet", RX_Packet, 4'b0010);
        chk("ack_done_inactive", RX_Transfer_Active, 0);
        tick();
        chk("ack_idle", c_state_RX, 0);
        chk("ack_ready_low", RX_Data_Ready, 0);
        chk("ack_packet_hold", RX_Packet, 4'b0010);
        #1;
        chk("ack_ready_count", ready_cnt, 1);
        chk("ack_no_store", stores.size(), 0);

        // DATA0, three payload bytes plus CRC
        send_byte(8'h01);
        send_byte(8'hC3);
        chk("d0_state", c_state_RX, 3);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("d0_no_store_yet", store_RX_data, 0);
        send_byte(8'hCC);
        chk("d0_store_aa_pulse", store_RX_data, 1);
        chk("d0_store_aa_data", RX_data, 8'hAA);
        send_byte(8'h12);
        send_byte(8'h34);
        send_eop();
        chk("d0_done", c_state_RX, 5);
        chk("d0_packet", RX_Packet, 4'b0011);
        tick();
        #1;
        chk("d0_store_count", stores.size(), 3);
        if (stores.size() == 3) begin
            chk("d0_store0", stores[0], 8'hAA);
            chk("d0_store1", stores[1], 8'hBB);
            chk("d0_store2", stores[2], 8'hCC);
        end
        chk("d0_ready_count", ready_cnt, 2);
        stores.delete();

        // OUT token
        send_byte(8'h01);
        send_byte(8'hE1);
        chk("out_token_state", c_state_RX, 2);
        send_byte(8'h8A);
        send_byte(8'h5F);
        send_eop();
        chk("out_done", c_state_RX, 5);
        chk("out_token", token_RX, 16'h8A5F);
        chk("out_packet", RX_Packet, 4'b0001);
        tick();

        // Token with a third byte
        send_byte(8'h01);
        send_byte(8'hE1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("tok3_error", c_state_RX, 6);
        chk("tok3_err_flag", RX_Error, 1);
        send_eop();
        chk("tok3_idle", c_state_RX, 0);
        chk("tok3_err_sticky", RX_Error, 1);

        // Bad SYNC
        send_byte(8'h80);
        chk("sync_error", c_state_RX, 6);
        send_byte(8'h01);
        chk("sync_err_ignores_byte", c_state_RX, 6);
        send_eop();
        chk("sync_idle", c_state_RX, 0);
        chk("sync_err_held", RX_Error, 1);
        send_byte(8'h01);
        chk("sync_err_cleared", RX_Error, 0);
        send_eop();
        chk("pid_eop_error", c_state_RX, 6);
        send_eop();

        // Overflow: 67 bytes after PID
        send_byte(8'h01);
        send_byte(8'hC3);
        for (int i = 0; i < 66; i++) send_byte(8'(i));
        chk("ovf_still_data", c_state_RX, 3);
        send_byte(8'hFF);
        chk("ovf_error", c_state_RX, 6);
        chk("ovf_no_store", store_RX_data, 0);
        send_eop();
        #1;
        chk("ovf_store_count", stores.size(), 64);
        if (stores.size() == 64) chk("ovf_last_store", stores[63], 8'd63);
        chk("ovf_no_ready", ready_cnt, 3);
        chk("ovf_packet_kept", RX_Packet, 4'b0001);
        stores.delete();

        // Short DATA and same-cycle strobes
        send_byte(8'h01);
        send_byte(8'hC3);
        send_byte(8'hAA);
        send_eop();
        chk("short_data_error", c_state_RX, 6);
        send_eop();
        send_byte(8'h01);
        send_byte(8'hC3);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        send_both(8'h40);
        chk("both_error", c_state_RX, 6);
        chk("both_no_store", store_RX_data, 0);
        send_eop();
        #1;
        chk("both_store_count", stores.size(), 1);
        stores.delete();

        // PID byte 03
        send_byte(8'h01);
        send_byte(8'h03);
`ifdef USB_RX_PID_CHECK_EN
        chk("pid03_rejected", c_state_RX, 6);
        send_eop();
        send_byte(8'h01);
        send_byte(8'hC3);
`else
        chk("pid03_accepted", c_state_RX, 3);
`endif
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        chk("pre_rst_store", store_RX_data, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_state", c_state_RX, 0);
        chk("mid_rst_store", store_RX_data, 0);
        chk("mid_rst_data", RX_data, 0);
        chk("mid_rst_packet", RX_Packet, 0);
        chk("mid_rst_token", token_RX, 0);
        chk("mid_rst_active", RX_Transfer_Active, 0);
        chk("mid_rst_err", RX_Error, 0);
        rst = 1'b0;
        tick();
        #1;
        chk("final_ready_count", ready_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
